// File: rtl/kgp_ctrl_pkg.sv
// Shared definitions for the KGP-RISC multicycle control sequencer:
// opcode/funct encodings, state and instruction-class enums, datapath
// select encodings and the instruction classifier.
package kgp_ctrl_pkg;

    // Opcode field IR[31:28]
    localparam logic [3:0] OP_ALU0  = 4'b0000;
    localparam logic [3:0] OP_ALU1  = 4'b0001;
    localparam logic [3:0] OP_ALU2  = 4'b0010;
    localparam logic [3:0] OP_ALU3  = 4'b0011;
    localparam logic [3:0] OP_JUMP  = 4'b0100;
    localparam logic [3:0] OP_BCOND = 4'b0101;
    localparam logic [3:0] OP_LW    = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Function field for the JUMP opcode
    localparam logic [3:0] FN_BR = 4'b0000;  // register target
    localparam logic [3:0] FN_BL = 4'b0001;  // branch and link
    localparam logic [3:0] FN_B  = 4'b0010;  // branch target

    // PC source select
    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_REG    = 2'd2;

    // Register-file write-back source select
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_JUMP,
        CL_BCOND,
        CL_LW,
        CL_SW,
        CL_HALT,
        CL_ILL
    } iclass_t;

    // State-aligned control strobes, held in a register while in a state
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       link_en;
        logic       alu_en;
    } ctrl_t;

    // Map opcode/funct onto an instruction class; unknown encodings are CL_ILL
    function automatic iclass_t classify(input logic [3:0] op, input logic [3:0] fn);
        iclass_t cls;
        case (op)
            OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3: cls = CL_ALU;
            OP_JUMP:  cls = (fn == FN_BR || fn == FN_BL || fn == FN_B) ? CL_JUMP : CL_ILL;
            OP_BCOND: cls = CL_BCOND;
            OP_LW:    cls = CL_LW;
            OP_SW:    cls = CL_SW;
            OP_HALT:  cls = CL_HALT;
            default:  cls = CL_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/kgp_ctrl_fsm_if.sv
// Control/handshake bundle between the sequencer (master) and the
// datapath plus instruction/data memories (slave).
interface kgp_ctrl_fsm_if #(
    parameter int unsigned RET_CNT_W = 32
);
    logic [3:0]           opcode;
    logic [3:0]           funct;
    logic                 cond_true;
    logic                 imem_ack;
    logic                 dmem_ack;

    logic                 imem_req;
    logic                 dmem_req;
    logic                 dmem_we;
    logic                 ir_we;
    logic                 pc_we;
    logic [1:0]           pc_sel;
    logic                 reg_we;
    logic [1:0]           wb_sel;
    logic                 link_en;
    logic                 alu_en;
    logic                 halted;
    logic                 illegal;
    logic                 bus_err;
    logic [RET_CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, cond_true, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
               reg_we, wb_sel, link_en, alu_en, halted, illegal, bus_err, retired
    );

    modport slave (
        output opcode, funct, cond_true, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
               reg_we, wb_sel, link_en, alu_en, halted, illegal, bus_err, retired
    );
endinterface

// File: rtl/kgp_mem_wait_timer.sv
// Memory wait counter shared by instruction fetch and data access.
// timeout is high while the current cycle is the LIMIT-th cycle of the
// wait, so an un-acked cycle with timeout set is the last one allowed.
module kgp_mem_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Count un-acked request cycles; cleared whenever a new wait begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/kgp_ctrl_fsm.sv
// KGP-RISC multicycle control sequencer: FETCH, DECODE, EXEC, MEM, WB with
// terminal HALT/TRAP states. State-aligned strobes are registered from the
// next-state decode; only the handshake-qualified strobes (ir_we on imem_ack,
// store pc_we on dmem_ack, conditional-branch pc_sel) combine the registered
// state with the live input.
module kgp_ctrl_fsm
    import kgp_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RET_CNT_W   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    kgp_ctrl_fsm_if.master bus
);

    state_t               state;
    state_t               next_state;
    iclass_t              cls_q;
    iclass_t              cls_d;
    iclass_t              cls_n;
    logic [3:0]           fn_q;
    logic [3:0]           fn_n;
    ctrl_t                ctrl_q;
    ctrl_t                ctrl_d;
    logic                 halted_q;
    logic                 illegal_q;
    logic                 bus_err_q;
    logic                 halted_d;
    logic                 illegal_d;
    logic                 bus_err_d;
    logic [RET_CNT_W-1:0] retired_q;

    logic                 fetch_ack;
    logic                 mem_ack;
    logic                 waiting;
    logic                 wait_clr;
    logic                 wait_timeout;
    logic                 retire;

    // The fetch handshake only counts once the request is actually on the bus
    assign fetch_ack = (state == ST_FETCH) && ctrl_q.imem_req && bus.imem_ack;
    assign mem_ack   = (state == ST_MEM) && bus.dmem_ack;
    assign waiting   = ((state == ST_FETCH) && ctrl_q.imem_req && !bus.imem_ack) ||
                       ((state == ST_MEM) && !bus.dmem_ack);
    assign cls_d     = classify(bus.opcode, bus.funct);

    // Decode is live in DECODE and comes from the latched copy afterwards
    assign cls_n = (state == ST_DECODE) ? cls_d : cls_q;
    assign fn_n  = (state == ST_DECODE) ? bus.funct : fn_q;

    // Every instruction completes on the transition back into FETCH
    assign retire   = (state != ST_FETCH) && (next_state == ST_FETCH);
    assign wait_clr = (next_state != state) &&
                      ((next_state == ST_FETCH) || (next_state == ST_MEM));

    kgp_mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wait_clr),
        .en      (waiting),
        .timeout (wait_timeout)
    );

    // State, latched instruction class, sticky status and retired count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            cls_q     <= CL_ALU;
            fn_q      <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state     <= next_state;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            if (state == ST_DECODE) begin
                cls_q <= cls_d;
                fn_q  <= bus.funct;
            end
            if (retire) begin
                retired_q <= retired_q + RET_CNT_W'(1);
            end
        end
    end

    // Next-state selection and sticky-flag updates
    always_comb begin
        next_state = state;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        case (state)
            ST_FETCH: begin
                if (fetch_ack) begin
                    next_state = ST_DECODE;
                end else if (waiting && wait_timeout) begin
                    next_state = ST_TRAP;
                    bus_err_d  = 1'b1;
                end
            end
            ST_DECODE: begin
                case (cls_d)
                    CL_HALT: begin
                        next_state = ST_HALT;
                        halted_d   = 1'b1;
                    end
                    CL_ILL: begin
                        next_state = ST_TRAP;
                        illegal_d  = 1'b1;
                    end
                    default: next_state = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cls_q)
                    CL_ALU:       next_state = ST_WB;
                    CL_LW, CL_SW: next_state = ST_MEM;
                    default:      next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    next_state = (cls_q == CL_SW) ? ST_FETCH : ST_WB;
                end else if (wait_timeout) begin
                    next_state = ST_TRAP;
                    bus_err_d  = 1'b1;
                end
            end
            ST_WB:   next_state = ST_FETCH;
            default: next_state = state;
        endcase
    end

    // Control strobes for the state being entered
    always_comb begin
        ctrl_d = '0;
        case (next_state)
            ST_FETCH: ctrl_d.imem_req = 1'b1;
            ST_EXEC: begin
                ctrl_d.alu_en = 1'b1;
                if (cls_n == CL_JUMP) begin
                    ctrl_d.pc_we  = 1'b1;
                    ctrl_d.pc_sel = (fn_n == FN_BR) ? PC_SEL_REG : PC_SEL_BRANCH;
                    if (fn_n == FN_BL) begin
                        // Link write shares the PC-update edge, so it sees the old PC+4
                        ctrl_d.reg_we  = 1'b1;
                        ctrl_d.wb_sel  = WB_SEL_LINK;
                        ctrl_d.link_en = 1'b1;
                    end
                end else if (cls_n == CL_BCOND) begin
                    ctrl_d.pc_we = 1'b1;
                end
            end
            ST_MEM: begin
                ctrl_d.dmem_req = 1'b1;
                ctrl_d.dmem_we  = (cls_n == CL_SW);
            end
            ST_WB: begin
                ctrl_d.reg_we = 1'b1;
                ctrl_d.wb_sel = (cls_n == CL_LW) ? WB_SEL_MEM : WB_SEL_ALU;
                ctrl_d.pc_we  = 1'b1;
                ctrl_d.pc_sel = PC_SEL_PLUS4;
            end
            default: ctrl_d = '0;
        endcase
    end

    // Registered control strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.imem_req = ctrl_q.imem_req;
    assign bus.dmem_req = ctrl_q.dmem_req;
    assign bus.dmem_we  = ctrl_q.dmem_we;
    assign bus.reg_we   = ctrl_q.reg_we;
    assign bus.wb_sel   = ctrl_q.wb_sel;
    assign bus.link_en  = ctrl_q.link_en;
    assign bus.alu_en   = ctrl_q.alu_en;
    assign bus.halted   = halted_q;
    assign bus.illegal  = illegal_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.retired  = retired_q;

    // IR loads on the fetch ack; a store retires on its dmem_ack in MEM
    assign bus.ir_we  = fetch_ack;
    assign bus.pc_we  = ctrl_q.pc_we || (mem_ack && (cls_q == CL_SW));
    assign bus.pc_sel = ((state == ST_EXEC) && (cls_q == CL_BCOND)) ?
                        (bus.cond_true ? PC_SEL_BRANCH : PC_SEL_PLUS4) : ctrl_q.pc_sel;

endmodule

// File: tb/tb_kgp_ctrl_fsm.sv
// Self-checking bench for kgp_ctrl_fsm: directed cases followed by random
// instruction streams, compared cycle by cycle with a behavioural model.
module tb_kgp_ctrl_fsm;

    localparam int unsigned TMO = 16;
    localparam int unsigned RW  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    kgp_ctrl_fsm_if #(.RET_CNT_W(RW)) bus ();

    kgp_ctrl_fsm #(
        .MEM_TIMEOUT (TMO),
        .RET_CNT_W   (RW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic          imem_req;
        logic          dmem_req;
        logic          dmem_we;
        logic          ir_we;
        logic          pc_we;
        logic [1:0]    pc_sel;
        logic          reg_we;
        logic [1:0]    wb_sel;
        logic          link_en;
        logic          alu_en;
        logic          halted;
        logic          illegal;
        logic          bus_err;
        logic [RW-1:0] retired;
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    int   m_retired = 0;
    logic m_halted  = 1'b0;
    logic m_illegal = 1'b0;
    logic m_buserr  = 1'b0;

    // Expected outputs with no strobe active: only sticky flags and count
    function automatic obs_t idle();
        obs_t e;
        e         = '0;
        e.halted  = m_halted;
        e.illegal = m_illegal;
        e.bus_err = m_buserr;
        e.retired = RW'(m_retired);
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.imem_req = bus.imem_req;
        s.dmem_req = bus.dmem_req;
        s.dmem_we  = bus.dmem_we;
        s.ir_we    = bus.ir_we;
        s.pc_we    = bus.pc_we;
        s.pc_sel   = bus.pc_sel;
        s.reg_we   = bus.reg_we;
        s.wb_sel   = bus.wb_sel;
        s.link_en  = bus.link_en;
        s.alu_en   = bus.alu_en;
        s.halted   = bus.halted;
        s.illegal  = bus.illegal;
        s.bus_err  = bus.bus_err;
        s.retired  = bus.retired;
        return s;
    endfunction

    task automatic check(input obs_t exp, input string tag);
        obs_t got;
        #1;
        got = sample();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive acks, check mid-cycle, advance to edge+1
    task automatic cyc(input obs_t exp, input logic ia, input logic da, input string tag);
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        check(exp, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst_n        = 1'b0;
        m_retired    = 0;
        m_halted     = 1'b0;
        m_illegal    = 1'b0;
        m_buserr     = 1'b0;
        check(idle(), "reset_async");
        @(posedge clk);
        #1;
        check(idle(), "reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // no request is on the bus yet in the first cycle after release
        cyc(idle(), 1'b0, 1'b0, "reset_exit");
    endtask

    // Model of one instruction: fd/md are extra wait cycles before each ack
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input logic cond,
                             input int fd, input int md, input bit rst_in_mem);
        obs_t e;
        bit   is_alu, is_jmp, is_bc, is_lw, is_sw, is_halt, ack;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.cond_true = cond;
        for (int i = 0; i <= fd; i++) begin
            e          = idle();
            e.imem_req = 1'b1;
            e.ir_we    = (i == fd);
            cyc(e, (i == fd), 1'b0, "fetch");
        end
        cyc(idle(), 1'b0, 1'b0, "decode");
        is_alu  = (op <= 4'd3);
        is_jmp  = (op == 4'd4) && (fn <= 4'd2);
        is_bc   = (op == 4'd5);
        is_lw   = (op == 4'd6);
        is_sw   = (op == 4'd7);
        is_halt = (op == 4'd15);
        if (is_halt) begin
            m_halted = 1'b1;
            repeat (3) cyc(idle(), 1'b0, 1'b0, "halt_hold");
            return;
        end
        if (!(is_alu || is_jmp || is_bc || is_lw || is_sw)) begin
            m_illegal = 1'b1;
            repeat (3) cyc(idle(), 1'b0, 1'b0, "trap_illegal");
            return;
        end
        e        = idle();
        e.alu_en = 1'b1;
        if (is_jmp) begin
            e.pc_we  = 1'b1;
            e.pc_sel = (fn == 4'd0) ? 2'd2 : 2'd1;
            if (fn == 4'd1) begin
                e.reg_we  = 1'b1;
                e.wb_sel  = 2'd2;
                e.link_en = 1'b1;
            end
        end
        if (is_bc) begin
            e.pc_we  = 1'b1;
            e.pc_sel = cond ? 2'd1 : 2'd0;
        end
        cyc(e, 1'b0, 1'b0, "exec");
        if (is_jmp || is_bc) begin
            m_retired++;
            return;
        end
        if (is_lw || is_sw) begin
            for (int i = 0; i <= md && i < TMO; i++) begin
                ack        = (i == md);
                e          = idle();
                e.dmem_req = 1'b1;
                e.dmem_we  = is_sw;
                e.pc_we    = is_sw && ack;
                cyc(e, 1'b0, ack, "mem");
                if (rst_in_mem) begin
                    async_reset();
                    return;
                end
            end
            if (md >= TMO) begin
                m_buserr = 1'b1;
                repeat (3) cyc(idle(), 1'b0, 1'b0, "trap_bus");
                return;
            end
            if (is_sw) begin
                m_retired++;
                return;
            end
        end
        e        = idle();
        e.reg_we = 1'b1;
        e.pc_we  = 1'b1;
        e.wb_sel = is_lw ? 2'd1 : 2'd0;
        cyc(e, 1'b0, 1'b0, "wb");
        m_retired++;
    endtask

    initial begin
        int       k;
        logic [3:0] op, fn;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.cond_true = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.dmem_ack  = 1'b0;
        #1;
        async_reset();

        run_instr(4'b0000, 4'd0, 1'b0, 0, 0, 1'b0);   // ALU, zero wait
        run_instr(4'b0100, 4'b0001, 1'b0, 0, 0, 1'b0); // bl
        run_instr(4'b0101, 4'd0, 1'b0, 1, 0, 1'b0);   // bcond not taken
        run_instr(4'b0101, 4'd0, 1'b1, 0, 0, 1'b0);   // bcond taken
        run_instr(4'b0110, 4'd0, 1'b0, 0, 3, 1'b0);   // LW, ack after 3 waits
        run_instr(4'b0111, 4'd0, 1'b0, 0, 0, 1'b0);   // SW zero wait
        run_instr(4'b0111, 4'd0, 1'b0, 2, 2, 1'b0);   // SW with waits
        run_instr(4'b0100, 4'b0000, 1'b0, 0, 0, 1'b0); // br
        run_instr(4'b0100, 4'b0010, 1'b0, 0, 0, 1'b0); // b
        run_instr(4'b0110, 4'd0, 1'b0, 0, TMO - 1, 1'b0); // ack on the limit cycle wins
        for (int i = 0; i < 18; i++) begin
            run_instr(4'b0101, 4'd0, i[0], 0, 0, 1'b0);  // retired wraps past 2^RW
        end
        run_instr(4'b0110, 4'd0, 1'b0, 0, TMO, 1'b0); // dmem timeout
        async_reset();
        run_instr(4'b1010, 4'd0, 1'b0, 0, 0, 1'b0);   // undefined opcode
        async_reset();
        run_instr(4'b0100, 4'b0011, 1'b0, 0, 0, 1'b0); // undefined jump funct
        async_reset();
        run_instr(4'b0010, 4'd0, 1'b0, 0, 0, 1'b0);
        run_instr(4'b0110, 4'd0, 1'b0, 0, 5, 1'b1);   // reset while in MEM
        run_instr(4'b0001, 4'd0, 1'b0, 1, 0, 1'b0);
        run_instr(4'b1111, 4'd0, 1'b0, 0, 0, 1'b0);   // HALT
        async_reset();

        for (int n = 0; n < 60; n++) begin
            k  = int'($urandom_range(0, 9));
            fn = 4'($urandom_range(0, 15));
            case (k)
                0, 1, 2, 7: op = 4'($urandom_range(0, 3));
                3: begin
                    op = 4'b0100;
                    fn = 4'($urandom_range(0, 2));
                end
                4: op = 4'b0101;
                5: op = 4'b0110;
                6: op = 4'b0111;
                8: op = 4'($urandom_range(8, 14));
                default: op = 4'b1111;
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b0);
            if (m_halted || m_illegal || m_buserr) begin
                async_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
